// File: rtl/fft12_bfly_sched.sv
// fft12_bfly_sched: address/control sequencer for one in-place 12-point
// 3x2x2 mixed-radix FFT on the shared radix32bly butterfly. The read side is
// registered. The write side replays the read side RD_LAT cycles later.
module fft12_bfly_sched #(
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_rd_mask,
  output logic [ADDR_WIDTH-1:0] o_rd_addr0,
  output logic [ADDR_WIDTH-1:0] o_rd_addr1,
  output logic [ADDR_WIDTH-1:0] o_rd_addr2,
  output logic [2:0]            o_wr_mask,
  output logic [ADDR_WIDTH-1:0] o_wr_addr0,
  output logic [ADDR_WIDTH-1:0] o_wr_addr1,
  output logic [ADDR_WIDTH-1:0] o_wr_addr2,
  output logic                  o_c_r32,
  output logic [3:0]            o_tw1_exp,
  output logic [3:0]            o_tw2_exp,
  output logic [1:0]            o_stage
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

  // One butterfly's worth of control. The same record feeds the read port
  // (mask/addr) and, after the delay line, the write port plus datapath controls.
  typedef struct packed {
    logic [2:0]            mask;
    logic [ADDR_WIDTH-1:0] a0;
    logic [ADDR_WIDTH-1:0] a1;
    logic [ADDR_WIDTH-1:0] a2;
    logic                  c_r32;
    logic [3:0]            tw1;
    logic [3:0]            tw2;
    logic [1:0]            stage;
  } bfly_op_t;

  state_t     state, nxt_state;
  logic [1:0] stage, nxt_stage;
  logic [2:0] bfly, nxt_bfly;
  logic [1:0] wait_cnt, nxt_wait_cnt;
  logic       last_bfly;

  bfly_op_t        nxt_op;
  bfly_op_t        op_pipe [RD_LAT:0];
  logic [RD_LAT:0] vld_pipe;
  bfly_op_t        wr_op;

  // State register plus the stage/butterfly/bubble counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      stage    <= '0;
      bfly     <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= nxt_state;
      stage    <= nxt_stage;
      bfly     <= nxt_bfly;
      wait_cnt <= nxt_wait_cnt;
    end
  end

  // Next-state: issue a butterfly per RUN cycle, RD_LAT bubbles between stages
  always_comb begin
    nxt_state    = state;
    nxt_stage    = stage;
    nxt_bfly     = bfly;
    nxt_wait_cnt = wait_cnt;
    last_bfly    = (bfly == ((stage == 2'd0) ? 3'd3 : 3'd5));
    case (state)
      S_IDLE: begin
        if (i_start) begin
          nxt_state = S_RUN;
          nxt_stage = '0;
          nxt_bfly  = '0;
        end
      end
      S_RUN: begin
        if (last_bfly) begin
          nxt_bfly     = '0;
          nxt_wait_cnt = '0;
          nxt_state    = (stage == 2'd2) ? S_DRAIN : S_GAP;
        end else begin
          nxt_bfly = bfly + 3'd1;
        end
      end
      S_GAP: begin
        if (wait_cnt == LAT_LAST) begin
          nxt_state = S_RUN;
          nxt_stage = stage + 2'd1;
          nxt_bfly  = '0;
        end else begin
          nxt_wait_cnt = wait_cnt + 2'd1;
        end
      end
      S_DRAIN: begin
        if (wait_cnt == LAT_LAST) nxt_state = S_DONE;
        else                      nxt_wait_cnt = wait_cnt + 2'd1;
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Outputs: status decode, and the stage tables evaluated on the next
  // butterfly so the read side can be registered without an extra cycle
  always_comb begin
    o_busy = (state == S_RUN) || (state == S_GAP) || (state == S_DRAIN);
    o_done = (state == S_DONE);
    nxt_op = '0;
    if (nxt_state == S_RUN) begin
      nxt_op.stage = nxt_stage;
      case (nxt_stage)
        // radix-3 over k, k+4, k+8
        2'd0: begin
          nxt_op.mask  = 3'b111;
          nxt_op.a0    = ADDR_WIDTH'({2'b00, nxt_bfly[1:0]});
          nxt_op.a1    = ADDR_WIDTH'({2'b01, nxt_bfly[1:0]});
          nxt_op.a2    = ADDR_WIDTH'({2'b10, nxt_bfly[1:0]});
          nxt_op.c_r32 = 1'b1;
          nxt_op.tw1   = 4'd4;
          nxt_op.tw2   = 4'd8;
        end
        // radix-2 over 4g+j, 4g+j+2 with g = bfly>>1, j = bfly&1
        2'd1: begin
          nxt_op.mask = 3'b011;
          nxt_op.a0   = ADDR_WIDTH'({nxt_bfly[2:1], 1'b0, nxt_bfly[0]});
          nxt_op.a1   = ADDR_WIDTH'({nxt_bfly[2:1], 1'b1, nxt_bfly[0]});
          nxt_op.tw1  = nxt_bfly[0] ? 4'd3 : 4'd0;
        end
        // radix-2 over adjacent pairs 2m, 2m+1, no twiddle
        2'd2: begin
          nxt_op.mask = 3'b011;
          nxt_op.a0   = ADDR_WIDTH'({nxt_bfly, 1'b0});
          nxt_op.a1   = ADDR_WIDTH'({nxt_bfly, 1'b1});
        end
        default: nxt_op = '0;
      endcase
    end
  end

  // Read-side register and RD_LAT-deep replay line toward the write side
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i <= RD_LAT; i++) op_pipe[i] <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[RD_LAT-1:0], (nxt_op.mask != 3'b000)};
      op_pipe[0] <= nxt_op;
      for (int i = 1; i <= RD_LAT; i++) op_pipe[i] <= op_pipe[i-1];
    end
  end

  assign wr_op = vld_pipe[RD_LAT] ? op_pipe[RD_LAT] : '0;

  assign o_rd_mask  = op_pipe[0].mask;
  assign o_rd_addr0 = op_pipe[0].a0;
  assign o_rd_addr1 = op_pipe[0].a1;
  assign o_rd_addr2 = op_pipe[0].a2;

  assign o_wr_mask  = wr_op.mask;
  assign o_wr_addr0 = wr_op.a0;
  assign o_wr_addr1 = wr_op.a1;
  assign o_wr_addr2 = wr_op.a2;
  assign o_c_r32    = wr_op.c_r32;
  assign o_tw1_exp  = wr_op.tw1;
  assign o_tw2_exp  = wr_op.tw2;
  assign o_stage    = wr_op.stage;

endmodule

// File: tb/tb_fft12_bfly_sched.sv
// tb_fft12_bfly_sched: directed bench running RD_LAT=1 and RD_LAT=2 sequencers
// side by side against hand-written butterfly and cycle tables.
module tb_fft12_bfly_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start;

  logic       d1_busy, d1_done, d1_cr;
  logic [2:0] d1_rdm, d1_wrm;
  logic [3:0] d1_r0, d1_r1, d1_r2, d1_w0, d1_w1, d1_w2, d1_t1, d1_t2;
  logic [1:0] d1_st;

  logic       d2_busy, d2_done, d2_cr;
  logic [2:0] d2_rdm, d2_wrm;
  logic [3:0] d2_r0, d2_r1, d2_r2, d2_w0, d2_w1, d2_w2, d2_t1, d2_t2;
  logic [1:0] d2_st;

  fft12_bfly_sched #(.ADDR_WIDTH(4), .RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(d1_busy), .o_done(d1_done),
    .o_rd_mask(d1_rdm), .o_rd_addr0(d1_r0), .o_rd_addr1(d1_r1), .o_rd_addr2(d1_r2),
    .o_wr_mask(d1_wrm), .o_wr_addr0(d1_w0), .o_wr_addr1(d1_w1), .o_wr_addr2(d1_w2),
    .o_c_r32(d1_cr), .o_tw1_exp(d1_t1), .o_tw2_exp(d1_t2), .o_stage(d1_st)
  );

  fft12_bfly_sched #(.ADDR_WIDTH(4), .RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_busy(d2_busy), .o_done(d2_done),
    .o_rd_mask(d2_rdm), .o_rd_addr0(d2_r0), .o_rd_addr1(d2_r1), .o_rd_addr2(d2_r2),
    .o_wr_mask(d2_wrm), .o_wr_addr0(d2_w0), .o_wr_addr1(d2_w1), .o_wr_addr2(d2_w2),
    .o_c_r32(d2_cr), .o_tw1_exp(d2_t1), .o_tw2_exp(d2_t2), .o_stage(d2_st)
  );

  int total = 0;
  int bad   = 0;

  // Butterfly i in issue order: addresses packed {a2,a1,a0}
  logic [11:0] exp_addr [16];
  logic [3:0]  exp_tw1  [16];
  logic [1:0]  exp_st   [16];
  // Issue cycle of butterfly i with the start accepted in cycle 0
  int          iss1     [16];
  int          iss2     [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int iss_of(input int id, input int i);
    return (id == 0) ? iss1[i] : iss2[i];
  endfunction

  function automatic logic [31:0] exp_ctl(input int id, input int c);
    int last_busy = (id == 0) ? 19 : 22;
    int done_c    = (id == 0) ? 20 : 23;
    return {30'd0, (c >= 1 && c <= last_busy), (c == done_c)};
  endfunction

  function automatic logic [31:0] exp_rd(input int id, input int c);
    logic [31:0] r = '0;
    for (int i = 0; i < 16; i++)
      if (iss_of(id, i) == c) r = {17'd0, (i < 4) ? 3'b111 : 3'b011, exp_addr[i]};
    return r;
  endfunction

  function automatic logic [31:0] exp_wr(input int id, input int c);
    logic [31:0] r = '0;
    for (int i = 0; i < 16; i++)
      if (iss_of(id, i) + id + 1 == c)
        r = {6'd0, (i < 4) ? 3'b111 : 3'b011, exp_addr[i], (i < 4),
             exp_tw1[i], (i < 4) ? 4'd8 : 4'd0, exp_st[i]};
    return r;
  endfunction

  task automatic chk_d1(input int c);
    chk($sformatf("L1 c%0d ctl", c), {30'd0, d1_busy, d1_done}, exp_ctl(0, c));
    chk($sformatf("L1 c%0d rd", c), {17'd0, d1_rdm, d1_r2, d1_r1, d1_r0}, exp_rd(0, c));
    chk($sformatf("L1 c%0d wr", c),
        {6'd0, d1_wrm, d1_w2, d1_w1, d1_w0, d1_cr, d1_t1, d1_t2, d1_st}, exp_wr(0, c));
  endtask

  task automatic chk_d2(input int c);
    chk($sformatf("L2 c%0d ctl", c), {30'd0, d2_busy, d2_done}, exp_ctl(1, c));
    chk($sformatf("L2 c%0d rd", c), {17'd0, d2_rdm, d2_r2, d2_r1, d2_r0}, exp_rd(1, c));
    chk($sformatf("L2 c%0d wr", c),
        {6'd0, d2_wrm, d2_w2, d2_w1, d2_w0, d2_cr, d2_t1, d2_t2, d2_st}, exp_wr(1, c));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " L1"}, {6'd0, d1_busy, d1_done, d1_rdm, d1_r2, d1_r1, d1_r0, d1_wrm, d1_w2,
                       d1_w1, d1_w0}, 32'd0);
    chk({tag, " L1 ctl"}, {19'd0, d1_cr, d1_t1, d1_t2, d1_st}, 32'd0);
    chk({tag, " L2"}, {6'd0, d2_busy, d2_done, d2_rdm, d2_r2, d2_r1, d2_r0, d2_wrm, d2_w2,
                       d2_w1, d2_w0}, 32'd0);
    chk({tag, " L2 ctl"}, {19'd0, d2_cr, d2_t1, d2_t2, d2_st}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_addr = '{12'h840, 12'h951, 12'hA62, 12'hB73,
                 12'h020, 12'h031, 12'h064, 12'h075, 12'h0A8, 12'h0B9,
                 12'h010, 12'h032, 12'h054, 12'h076, 12'h098, 12'h0BA};
    exp_tw1  = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd0, 4'd3, 4'd0, 4'd3, 4'd0, 4'd3,
                 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    exp_st   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    iss1     = '{1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 13, 14, 15, 16, 17, 18};
    iss2     = '{1, 2, 3, 4, 7, 8, 9, 10, 11, 12, 15, 16, 17, 18, 19, 20};

    // Reset held for 3 cycles: everything quiet
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) step();
    chk_quiet("reset");

    // Run A: start in cycle 0, start held high again in 3..21 (ignored while
    // running; in cycle 21 the RD_LAT=1 unit is back in IDLE and restarts)
    rst_n = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      step();
      start = (c >= 3 && c <= 21);
      if (c <= 21) chk_d1(c);
      if (c == 22) begin
        chk("L1 restart rd", {17'd0, d1_rdm, d1_r2, d1_r1, d1_r0}, {17'd0, 3'b111, 12'h840});
        chk("L1 restart busy", {30'd0, d1_busy, d1_done}, 32'd2);
      end
      if (c == 41) chk("L1 second done", {31'd0, d1_done}, 32'd1);
      chk_d2(c);
    end

    // Run B: reset asserted in cycle 10 aborts both units mid-stage
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      start = 1'b0;
      if (c <= 10) begin
        chk_d1(c);
        chk_d2(c);
      end else begin
        chk_quiet($sformatf("abort c%0d", c));
      end
      rst_n = (c != 10);
    end

    // Run C: clean full sequence after the abort
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      start = 1'b0;
      chk_d1(c);
      chk_d2(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
